// File: rtl/regfile_preload_seq.sv
// regfile_preload_seq
//
// Purpose:
//   Register-file preload sequencer. It buffers up to DEPTH (address, data)
//   entries from the host. On a `go` pulse it replays the entries into the
//   register-file write port, one per cycle, and holds the core stalled while
//   it does so. Entries whose address is >= NUM_REGS are skipped and set the
//   sticky addr_err flag.
//
// Optional feature (macro PRELOAD_VERIFY_EN):
//   When this macro is defined, a VERIFY pass follows the writes. It reads
//   every entry back through rf_raddr/rf_rdata and counts mismatches in
//   mismatch_cnt. When the macro is undefined, WRITE goes straight to DONE,
//   rf_raddr and mismatch_cnt are tied to 0, and rf_rdata is ignored.
//
// Ports:
//   clk, reset_n          clock (rising edge), async active-low reset
//   in_valid/in_ready     host entry handshake; in_addr/in_data carry the entry
//   go                    start replay (sampled only in IDLE)
//   busy, core_hold       high during WRITE/VERIFY (core stall request)
//   done                  one-cycle completion pulse
//   rf_we/rf_waddr/rf_wdata   register-file write port (registered)
//   rf_raddr/rf_rdata     register-file readback port (verify only)
//   count                 entries currently buffered
//   addr_err              sticky: an out-of-range entry was skipped
//   mismatch_cnt          verify mismatches from the last replay
module regfile_preload_seq #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2,
    parameter int DEPTH    = 8,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              go,
    output logic              busy,
    output logic              core_hold,
    output logic              done,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [CNT_W-1:0]  count,
    output logic              addr_err,
    output logic [CNT_W-1:0]  mismatch_cnt
);

    localparam int               IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_VERIFY,
        S_DONE
    } state_t;

    state_t state;

    logic [ADDR_W-1:0] buf_addr [DEPTH];
    logic [DATA_W-1:0] buf_data [DEPTH];

    logic [CNT_W-1:0]  idx;
    logic [CNT_W-1:0]  idx_next;
    logic              accept;
    logic [CNT_W-1:0]  count_next;
    logic [ADDR_W-1:0] first_addr;
    logic [DATA_W-1:0] first_data;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_data;

    // The comparison is widened to 32 bits so that it stays meaningful even
    // when ADDR_W cannot express any out-of-range address.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (32'(a) < NUM_REGS);
    endfunction

    // Entries are accepted only in IDLE, while there is room, and never
    // while reset is held.
    assign in_ready   = reset_n && (state == S_IDLE) && (count < DEPTH_C);
    assign accept     = in_valid && in_ready;
    assign count_next = accept ? (count + CNT_ONE) : count;
    assign idx_next   = idx + CNT_ONE;

    // An entry that arrives in the same cycle as go, into an empty buffer,
    // becomes entry 0 before it reaches the buffer. It is therefore taken
    // straight from the input.
    assign first_addr = (count == '0) ? in_addr : buf_addr[0];
    assign first_data = (count == '0) ? in_data : buf_data[0];
    assign cur_addr   = buf_addr[idx[IDX_W-1:0]];
    assign cur_data   = buf_data[idx[IDX_W-1:0]];

    // Entry storage. It has no reset because its contents are meaningless
    // until count says otherwise.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_addr[count[IDX_W-1:0]] <= in_addr;
            buf_data[count[IDX_W-1:0]] <= in_data;
        end
    end

`ifdef PRELOAD_VERIFY_EN
    logic [ADDR_W-1:0] next_addr;
    assign next_addr = buf_addr[idx_next[IDX_W-1:0]];
`else
    logic unused_rdata;
    assign unused_rdata = ^rf_rdata;
    assign rf_raddr     = '0;
    assign mismatch_cnt = '0;
`endif

    // Sequencer FSM. All port-facing controls are registered. Each state
    // loads the value that the write/read ports need in the following cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            count     <= '0;
            idx       <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            busy      <= 1'b0;
            core_hold <= 1'b0;
            done      <= 1'b0;
            addr_err  <= 1'b0;
`ifdef PRELOAD_VERIFY_EN
            rf_raddr     <= '0;
            mismatch_cnt <= '0;
`endif
        end else begin
            done  <= 1'b0;
            rf_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    count <= count_next;
                    if (go) begin
                        if (count_next == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= S_WRITE;
                            busy      <= 1'b1;
                            core_hold <= 1'b1;
                            rf_we     <= addr_ok(first_addr);
                            rf_waddr  <= first_addr;
                            rf_wdata  <= first_data;
                            addr_err  <= !addr_ok(first_addr);
                            idx       <= CNT_ONE;
`ifdef PRELOAD_VERIFY_EN
                            mismatch_cnt <= '0;
`endif
                        end
                    end
                end
                // idx points at the next entry to present. Once it reaches
                // count, the last write has just landed.
                S_WRITE: begin
                    if (idx == count) begin
                        rf_waddr <= '0;
                        rf_wdata <= '0;
`ifdef PRELOAD_VERIFY_EN
                        state    <= S_VERIFY;
                        idx      <= '0;
                        rf_raddr <= buf_addr[0];
`else
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        core_hold <= 1'b0;
                        done      <= 1'b1;
`endif
                    end else begin
                        rf_we    <= addr_ok(cur_addr);
                        rf_waddr <= cur_addr;
                        rf_wdata <= cur_data;
                        if (!addr_ok(cur_addr)) begin
                            addr_err <= 1'b1;
                        end
                        idx <= idx_next;
                    end
                end
`ifdef PRELOAD_VERIFY_EN
                // idx points at the entry being read in this cycle. Its read
                // data is compared at the end of the cycle.
                S_VERIFY: begin
                    if (addr_ok(cur_addr) && (rf_rdata != cur_data)) begin
                        mismatch_cnt <= mismatch_cnt + CNT_ONE;
                    end
                    if (idx_next == count) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        core_hold <= 1'b0;
                        done      <= 1'b1;
                        rf_raddr  <= '0;
                        idx       <= '0;
                    end else begin
                        idx      <= idx_next;
                        rf_raddr <= next_addr;
                    end
                end
`endif
                S_DONE: begin
                    count <= '0;
                    idx   <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_preload_seq.sv
// tb_regfile_preload_seq
//
// Purpose:
//   Directed bench for regfile_preload_seq. It includes a behavioural
//   register file, optionally with a corruption hook on R1. The DUT is built
//   with ADDR_W=3 so that addresses >= NUM_REGS can be expressed. Expected
//   timing follows PRELOAD_VERIFY_EN when that macro is defined.
module tb_regfile_preload_seq;

    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 4;
    localparam int ADDR_W   = 3;
    localparam int DEPTH    = 8;
    localparam int CNT_W    = 4;

`ifdef PRELOAD_VERIFY_EN
    localparam int VERIFY_ON = 1;
`else
    localparam int VERIFY_ON = 0;
`endif

    logic              clk;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              go;
    logic              busy;
    logic              core_hold;
    logic              done;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [ADDR_W-1:0] rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic [CNT_W-1:0]  count;
    logic              addr_err;
    logic [CNT_W-1:0]  mismatch_cnt;

    logic [DATA_W-1:0] rf_mem [1 << ADDR_W];
    logic              corrupt_r1;

    int total;
    int bad;
    int write_cnt;
    int done_cnt;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              exp_we;
    } vec_t;

    vec_t vecs [8];

    regfile_preload_seq #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_addr     (in_addr),
        .in_data     (in_data),
        .go          (go),
        .busy        (busy),
        .core_hold   (core_hold),
        .done        (done),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .rf_raddr    (rf_raddr),
        .rf_rdata    (rf_rdata),
        .count       (count),
        .addr_err    (addr_err),
        .mismatch_cnt(mismatch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model. When the corruption hook is armed, every write
    // to R1 stores 0x03, so a later readback of R1 disagrees.
    always @(posedge clk) begin
        if (rf_we) begin
            rf_mem[rf_waddr] <= (corrupt_r1 && rf_waddr == 3'd1) ? 8'h03 : rf_wdata;
        end
    end
    assign rf_rdata = rf_mem[rf_raddr];

    // Event monitors for write and done pulses.
    always @(posedge clk) begin
        if (rf_we) write_cnt++;
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs, let the edge sample them, then idle them.
    task automatic applyStimulus(input logic v, input logic [ADDR_W-1:0] a,
                                 input logic [DATA_W-1:0] d, input logic g);
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        go       = g;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        go       = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance until done is seen, within a bounded budget. cyc reports the
    // replay cycle in which done was observed.
    task automatic waitDone(input int start, output int cyc);
        cyc = start;
        while (done !== 1'b1 && cyc < start + 40) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int w0;
        int d0;

        total      = 0;
        bad        = 0;
        write_cnt  = 0;
        done_cnt   = 0;
        corrupt_r1 = 1'b0;
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_addr    = '0;
        in_data    = '0;
        go         = 1'b0;

        vecs[0] = '{3'd0, 8'h10, 1'b1};
        vecs[1] = '{3'd1, 8'h21, 1'b1};
        vecs[2] = '{3'd2, 8'h32, 1'b1};
        vecs[3] = '{3'd3, 8'h43, 1'b1};
        vecs[4] = '{3'd6, 8'h5A, 1'b0};
        vecs[5] = '{3'd1, 8'h65, 1'b1};
        vecs[6] = '{3'd2, 8'h76, 1'b1};
        vecs[7] = '{3'd0, 8'h87, 1'b1};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_rf_we", 32'(rf_we), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        reset_n = 1'b1;
        tick();
        checkOutput("rst_in_ready", 32'(in_ready), 1);
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_core_hold", 32'(core_hold), 0);
        checkOutput("rst_addr_err", 32'(addr_err), 0);
        checkOutput("rst_mismatch", 32'(mismatch_cnt), 0);

        // Table run: fill the buffer, with duplicates and an out-of-range entry.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, vecs[i].addr, vecs[i].data, 1'b0);
        end
        in_valid = 1'b1;
        in_addr  = 3'd2;
        in_data  = 8'hEE;
        #1;
        checkOutput("full_in_ready", 32'(in_ready), 0);
        checkOutput("full_count", 32'(count), 8);
        tick();
        checkOutput("full_count_hold", 32'(count), 8);
        in_valid = 1'b0;
        w0 = write_cnt;
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("tab_we_%0d", i), 32'(rf_we), 32'(vecs[i].exp_we));
            checkOutput($sformatf("tab_hold_%0d", i), 32'(core_hold), 1);
            if (vecs[i].exp_we) begin
                checkOutput($sformatf("tab_waddr_%0d", i), 32'(rf_waddr), 32'(vecs[i].addr));
                checkOutput($sformatf("tab_wdata_%0d", i), 32'(rf_wdata), 32'(vecs[i].data));
            end
            tick();
        end
        waitDone(9, cyc);
        checkOutput("tab_done_cycle", 32'(cyc), (VERIFY_ON != 0) ? 17 : 9);
        checkOutput("tab_busy_done", 32'(busy), 0);
        checkOutput("tab_addr_err", 32'(addr_err), 1);
        checkOutput("tab_mismatch", 32'(mismatch_cnt), (VERIFY_ON != 0) ? 3 : 0);
        tick();
        checkOutput("tab_count_after", 32'(count), 0);
        checkOutput("tab_ready_after", 32'(in_ready), 1);
        checkOutput("tab_writes", 32'(write_cnt - w0), 7);
        checkOutput("tab_r0", 32'(rf_mem[0]), 32'h87);
        checkOutput("tab_r1", 32'(rf_mem[1]), 32'h65);
        checkOutput("tab_r2", 32'(rf_mem[2]), 32'h76);
        checkOutput("tab_r3", 32'(rf_mem[3]), 32'h43);

        // Basic two-entry replay; go clears the sticky status.
        applyStimulus(1'b1, 3'd0, 8'h06, 1'b0);
        applyStimulus(1'b1, 3'd1, 8'h02, 1'b0);
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b1);
        checkOutput("two_we_c1", 32'(rf_we), 1);
        checkOutput("two_waddr_c1", 32'(rf_waddr), 0);
        checkOutput("two_wdata_c1", 32'(rf_wdata), 32'h06);
        checkOutput("two_busy_c1", 32'(busy), 1);
        checkOutput("two_ready_c1", 32'(in_ready), 0);
        tick();
        checkOutput("two_we_c2", 32'(rf_we), 1);
        checkOutput("two_waddr_c2", 32'(rf_waddr), 1);
        checkOutput("two_wdata_c2", 32'(rf_wdata), 32'h02);
        tick();
        checkOutput("two_we_c3", 32'(rf_we), 0);
        waitDone(3, cyc);
        checkOutput("two_done_cycle", 32'(cyc), (VERIFY_ON != 0) ? 5 : 3);
        checkOutput("two_hold_done", 32'(core_hold), 0);
        checkOutput("two_mismatch", 32'(mismatch_cnt), 0);
        checkOutput("two_addr_err", 32'(addr_err), 0);
        tick();
        checkOutput("two_done_low", 32'(done), 0);
        checkOutput("two_r0", 32'(rf_mem[0]), 32'h06);
        checkOutput("two_r1", 32'(rf_mem[1]), 32'h02);

        // Out-of-range entry is skipped.
        w0 = write_cnt;
        applyStimulus(1'b1, 3'd5, 8'hAA, 1'b0);
        applyStimulus(1'b1, 3'd2, 8'h11, 1'b0);
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b1);
        checkOutput("oor_we_c1", 32'(rf_we), 0);
        checkOutput("oor_busy_c1", 32'(busy), 1);
        tick();
        checkOutput("oor_we_c2", 32'(rf_we), 1);
        checkOutput("oor_waddr_c2", 32'(rf_waddr), 2);
        checkOutput("oor_wdata_c2", 32'(rf_wdata), 32'h11);
        tick();
        waitDone(3, cyc);
        checkOutput("oor_done_cycle", 32'(cyc), (VERIFY_ON != 0) ? 5 : 3);
        checkOutput("oor_addr_err", 32'(addr_err), 1);
        checkOutput("oor_mismatch", 32'(mismatch_cnt), 0);
        tick();
        checkOutput("oor_writes", 32'(write_cnt - w0), 1);
        checkOutput("oor_r2", 32'(rf_mem[2]), 32'h11);

        // The corrupted R1 shows up as a single verify mismatch.
        applyStimulus(1'b1, 3'd0, 8'h44, 1'b0);
        applyStimulus(1'b1, 3'd1, 8'h55, 1'b0);
        corrupt_r1 = 1'b1;
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b1);
        waitDone(1, cyc);
        corrupt_r1 = 1'b0;
        checkOutput("cor_done_cycle", 32'(cyc), (VERIFY_ON != 0) ? 5 : 3);
        checkOutput("cor_mismatch", 32'(mismatch_cnt), (VERIFY_ON != 0) ? 1 : 0);
        tick();

        // go with an empty buffer.
        w0 = write_cnt;
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b1);
        checkOutput("emp_done_c1", 32'(done), 1);
        checkOutput("emp_hold_c1", 32'(core_hold), 0);
        checkOutput("emp_busy_c1", 32'(busy), 0);
        checkOutput("emp_we_c1", 32'(rf_we), 0);
        tick();
        checkOutput("emp_done_c2", 32'(done), 0);
        checkOutput("emp_ready_c2", 32'(in_ready), 1);
        checkOutput("emp_writes", 32'(write_cnt - w0), 0);

        // Entry and go in the same cycle; a go during WRITE is ignored.
        applyStimulus(1'b1, 3'd3, 8'h99, 1'b1);
        checkOutput("same_we_c1", 32'(rf_we), 1);
        checkOutput("same_waddr_c1", 32'(rf_waddr), 3);
        checkOutput("same_wdata_c1", 32'(rf_wdata), 32'h99);
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b1);
        waitDone(2, cyc);
        checkOutput("same_done_cycle", 32'(cyc), (VERIFY_ON != 0) ? 3 : 2);
        tick();
        checkOutput("same_busy_after", 32'(busy), 0);
        checkOutput("same_ready_after", 32'(in_ready), 1);
        tick();
        checkOutput("same_busy_idle", 32'(busy), 0);
        checkOutput("same_r3", 32'(rf_mem[3]), 32'h99);

        // Reset asserted during the third of five writes.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, ADDR_W'(i % 4), 8'hC1 + 8'(i), 1'b0);
        end
        w0 = write_cnt;
        d0 = done_cnt;
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b1);
        tick();
        tick();
        checkOutput("rmid_we_c3", 32'(rf_we), 1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rmid_we_async", 32'(rf_we), 0);
        checkOutput("rmid_hold_async", 32'(core_hold), 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) tick();
        checkOutput("rmid_ready", 32'(in_ready), 1);
        checkOutput("rmid_count", 32'(count), 0);
        checkOutput("rmid_busy", 32'(busy), 0);
        checkOutput("rmid_writes", 32'(write_cnt - w0), 2);
        checkOutput("rmid_no_done", 32'(done_cnt - d0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_preload_seq.md
# regfile_preload_seq

Parametrised register-file preload sequencer sitting between the testbench/debug host and the processor register-file write port. It buffers up to DEPTH (address, data) writes, then on command replays them into the register file one per cycle while holding the core stalled. Optionally it reads every location back and counts mismatches. It replaces ad-hoc direct stimulus writes so that register initialisation is deterministic and cycle-exact.

## Interface
- DATA_W, 8, register data width
- NUM_REGS, 4, number of architectural registers
- ADDR_W, 2, register address width (≥ clog2(NUM_REGS))
- DEPTH, 8, preload buffer entries
- CNT_W, 4, width of entry/mismatch counters (≥ clog2(DEPTH+1))

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  host offers an entry
- in_ready  out  1  entry accepted when in_valid && in_ready
- in_addr  in  ADDR_W  target register
- in_data  in  DATA_W  value
- go  in  1  start replay (single-cycle pulse, sampled in IDLE only)
- busy  out  1  high in WRITE/VERIFY
- core_hold  out  1  stall request to core; equals busy
- done  out  1  one-cycle pulse on completion
- rf_we  out  1  register-file write enable
- rf_waddr  out  ADDR_W  write address
- rf_wdata  out  DATA_W  write data
- rf_raddr  out  ADDR_W  readback address (verify only)
- rf_rdata  in  DATA_W  combinational register-file read data
- count  out  CNT_W  entries currently buffered
- addr_err  out  1  sticky: entry with in_addr ≥ NUM_REGS was skipped
- mismatch_cnt  out  CNT_W  verify mismatches

## Operation
- States: IDLE, WRITE, VERIFY, DONE.
- IDLE: in_ready = (count < DEPTH). Accepted entries are stored at index count; count increments.
- go in IDLE: count = 0 → DONE; else → WRITE, index = 0, mismatch_cnt and addr_err cleared.
- WRITE: each cycle, entry[index] drives rf_waddr/rf_wdata, rf_we = 1. If the address ≥ NUM_REGS, rf_we = 0 and addr_err is set. index increments; after index = count−1 → VERIFY (macro defined) or DONE.
- VERIFY: each cycle, rf_raddr = entry[index].addr; rf_rdata is compared with entry[index].data at the cycle end, and mismatch_cnt increments on inequality. Out-of-range entries are skipped. After the last entry → DONE.
- Duplicate addresses: later entries win in the register file. Earlier duplicates report as mismatches in verify, by design.
- DONE: done = 1 for one cycle, count cleared → IDLE. addr_err and mismatch_cnt are held until the next go.
- in_ready = 0 outside IDLE. go outside IDLE is ignored. in_valid and go in the same IDLE cycle: the entry is accepted and included in the replay.
- Registered outputs: rf_we, rf_waddr, rf_wdata, rf_raddr, busy, core_hold, done.

## Timing
- Reset (async assert, sync release): state IDLE, count 0, all outputs 0, except in_ready = 1 once reset is released. Buffer contents are don't-care.
- go sampled at edge E0. Entry i is written at edge E0+1+i, with rf_we high in cycle 1+i.
- Without verify: done is high in cycle N+1 and busy drops in the same cycle.
- With verify: read of entry j occurs in cycle N+1+j, and done is high in cycle 2N+1.
- core_hold rises the cycle after go and falls in the done cycle.
- Reset mid-replay: immediate abort; rf_we is forced low asynchronously and no further writes occur.
- count saturates at DEPTH; pushes while full are not accepted.

## Configuration
- PRELOAD_VERIFY_EN defined: VERIFY state is present; rf_raddr and mismatch_cnt are active.
- PRELOAD_VERIFY_EN undefined: WRITE goes straight to DONE; rf_raddr and mismatch_cnt are tied to 0; rf_rdata is unused.

## Test plan
- Push (0,6), (1,2), go → rf_we in two consecutive cycles writing R0=6, R1=2. Done at cycle 3 without the macro, cycle 5 with it, and mismatch_cnt = 0.
- Push 8 entries at DEPTH=8, then a 9th with in_valid held → in_ready = 0 and count = 8. Go → 8 writes; after done, count = 0 and in_ready = 1.
- Push (5,0xAA) at NUM_REGS=4, then (2,0x11), go → only R2 is written, addr_err = 1, and no rf_we in the first replay cycle.
- Verify enabled; the model corrupts R1 to 0x03 after it is written → mismatch_cnt = 1 at done.
- Assert reset_n low during the 3rd of 5 writes → rf_we drops immediately, state is IDLE, count = 0, and no done pulse.
- go with an empty buffer → done pulses the next cycle, with no rf_we and no core_hold.
